// File: rtl/mem_read_responder.sv
// ============================================================================
// Module   : mem_read_responder
// Purpose  : 16-bit word memory target; writes land immediately, reads return
//            after LATENCY cycles through a {valid,data,err} shift pipeline.
//            Optional MEM_MISALIGN_ERR_EN flags odd-address reads, drops odd writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_read_responder #(
    parameter int LATENCY = 4,  // 1..8
    parameter int AW      = 12  // word-address width, at most 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        err
);

    localparam int c_DEPTH = 1 << AW;
    localparam int c_LAST  = LATENCY - 1;

    logic [15:0]   mem_q [c_DEPTH];

    logic          valid_q [LATENCY];
    logic [15:0]   data_q  [LATENCY];
    logic          err_q   [LATENCY];

    logic          valid_d;
    logic [15:0]   data_d;
    logic          err_d;

    logic          w_misalign;
    logic          w_rd;
    logic          w_wr;
    logic [AW-1:0] w_idx;
    logic          w_unused;

`ifdef MEM_MISALIGN_ERR_EN
    assign w_misalign = addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_idx    = addr[AW:1];
    assign w_unused = &{1'b0, addr[15:AW+1], addr[0]};
    assign w_rd     = enable & ~wr;
    // Gating with rst_n keeps writes presented during reset from landing.
    assign w_wr     = enable & wr & ~w_misalign & rst_n;

    always_comb begin
        valid_d = w_rd;
        data_d  = 16'h0000;
        err_d   = w_rd & w_misalign;
        if (w_rd) begin
            data_d = mem_q[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[w_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= 16'h0000;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= valid_d;
            data_q[0]  <= data_d;
            err_q[0]   <= err_d;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign data_valid = valid_q[c_LAST];
    assign data_out   = valid_q[c_LAST] ? data_q[c_LAST] : 16'h0000;
    assign err        = valid_q[c_LAST] & err_q[c_LAST];

endmodule

`default_nettype wire

// File: tb/tb_mem_read_responder.sv
// ============================================================================
// Module   : tb_mem_read_responder
// Purpose  : Directed self-checking bench for mem_read_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_read_responder;

    localparam int LAT = 4;
`ifdef MEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic        cap_v [64];
    logic [15:0] cap_d [64];
    logic        cap_e [64];
    int          cyc;

    mem_read_responder #(.LATENCY(LAT), .AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Present one request across a rising edge, then capture the outputs
    // of the cycle that edge opened.
    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        cap_v[cyc] = data_valid;
        cap_d[cyc] = data_out;
        cap_e[cyc] = err;
        cyc++;
        enable = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", data_valid); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got %h expected 0000", data_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic ev;
        cyc = 0;
        drive(1, 1, 16'h0010, 16'hBEEF);
        drive(1, 0, 16'h0010, 16'h0000);
        repeat (LAT + 3) drive(0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < cyc; k++) begin
            ev = (k == LAT);
            checks++; if (cap_v[k] !== ev) begin errors++; $display("FAIL basic_valid cyc %0d got %b expected %b", k, cap_v[k], ev); end
            checks++; if (cap_d[k] !== (ev ? 16'hBEEF : 16'h0000)) begin errors++; $display("FAIL basic_data cyc %0d got %h expected %h", k, cap_d[k], ev ? 16'hBEEF : 16'h0000); end
        end
    endtask

    task automatic test_back_to_back();
        int r;
        logic ev;
        logic [15:0] ed;
        cyc = 0;
        for (int i = 0; i < 8; i++) drive(1, 1, 16'h0040 + 16'(2*i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) drive(1, 0, 16'h0040 + 16'(2*i), 16'h0000);
        repeat (LAT + 2) drive(0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < cyc; k++) begin
            r  = k - (8 + LAT - 1);
            ev = (r >= 0) && (r < 8);
            ed = ev ? 16'h1000 + 16'(r) : 16'h0000;
            checks++; if (cap_v[k] !== ev) begin errors++; $display("FAIL b2b_valid cyc %0d got %b expected %b", k, cap_v[k], ev); end
            checks++; if (cap_d[k] !== ed) begin errors++; $display("FAIL b2b_data cyc %0d got %h expected %h", k, cap_d[k], ed); end
        end
    endtask

    task automatic test_snapshot();
        logic ev;
        logic [15:0] ed;
        cyc = 0;
        drive(1, 1, 16'h0020, 16'h1111);
        drive(1, 0, 16'h0020, 16'h0000);
        drive(1, 1, 16'h0020, 16'h2222);
        drive(1, 0, 16'h0020, 16'h0000);
        repeat (LAT + 2) drive(0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < cyc; k++) begin
            ev = (k == LAT) || (k == LAT + 2);
            ed = (k == LAT) ? 16'h1111 : (k == LAT + 2) ? 16'h2222 : 16'h0000;
            checks++; if (cap_v[k] !== ev) begin errors++; $display("FAIL snap_valid cyc %0d got %b expected %b", k, cap_v[k], ev); end
            checks++; if (cap_d[k] !== ed) begin errors++; $display("FAIL snap_data cyc %0d got %h expected %h", k, cap_d[k], ed); end
        end
    endtask

    task automatic test_alternate();
        logic ev;
        logic [15:0] ed;
        cyc = 0;
        drive(1, 0, 16'h0040, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        drive(1, 0, 16'h0042, 16'h0000);
        repeat (LAT + 2) drive(0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < cyc; k++) begin
            ev = (k == LAT - 1) || (k == LAT + 1);
            ed = (k == LAT - 1) ? 16'h1000 : (k == LAT + 1) ? 16'h1001 : 16'h0000;
            checks++; if (cap_v[k] !== ev) begin errors++; $display("FAIL alt_valid cyc %0d got %b expected %b", k, cap_v[k], ev); end
            checks++; if (cap_d[k] !== ed) begin errors++; $display("FAIL alt_data cyc %0d got %h expected %h", k, cap_d[k], ed); end
        end
    endtask

    task automatic test_reset_midflight();
        cyc = 0;
        drive(1, 0, 16'h0040, 16'h0000);
        drive(1, 0, 16'h0042, 16'h0000);
        drive(1, 0, 16'h0044, 16'h0000);
        drive(0, 0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        #1;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b expected 0", data_valid); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_async_data got %h expected 0000", data_out); end
        enable = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0; wr = 1'b0;
        rst_n = 1'b1;
        cyc = 0;
        repeat (LAT + 3) drive(0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < cyc; k++) begin
            checks++; if (cap_v[k] !== 1'b0) begin errors++; $display("FAIL rst_after_valid cyc %0d got %b expected 0", k, cap_v[k]); end
        end
        cyc = 0;
        drive(1, 0, 16'h0040, 16'h0000);
        repeat (LAT) drive(0, 0, 16'h0000, 16'h0000);
        checks++; if (cap_v[LAT-1] !== 1'b1) begin errors++; $display("FAIL rst_wr_ignored_valid got %b expected 1", cap_v[LAT-1]); end
        checks++; if (cap_d[LAT-1] !== 16'h1000) begin errors++; $display("FAIL rst_wr_ignored_data got %h expected 1000", cap_d[LAT-1]); end
    endtask

    task automatic test_misalign();
        logic ev;
        logic ee;
        logic [15:0] ed;
        cyc = 0;
        drive(1, 0, 16'h0011, 16'h0000);
        drive(1, 1, 16'h0011, 16'hDEAD);
        drive(1, 0, 16'h0010, 16'h0000);
        repeat (LAT + 2) drive(0, 0, 16'h0000, 16'h0000);
        for (int k = 0; k < cyc; k++) begin
            ev = (k == LAT - 1) || (k == LAT + 1);
            ee = (k == LAT - 1) && MIS;
            ed = (k == LAT - 1) ? 16'hBEEF : (k == LAT + 1) ? (MIS ? 16'hBEEF : 16'hDEAD) : 16'h0000;
            checks++; if (cap_v[k] !== ev) begin errors++; $display("FAIL mis_valid cyc %0d got %b expected %b", k, cap_v[k], ev); end
            checks++; if (cap_d[k] !== ed) begin errors++; $display("FAIL mis_data cyc %0d got %h expected %h", k, cap_d[k], ed); end
            checks++; if (cap_e[k] !== ee) begin errors++; $display("FAIL mis_err cyc %0d got %b expected %b", k, cap_e[k], ee); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_snapshot();
        test_alternate();
        test_reset_midflight();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_read_responder.md
# mem_read_responder

Word-oriented 16-bit memory responder serving as the target for the cache fill sequencer's read stream. Accepts one request per cycle (read or write), performs writes immediately and returns read data after a fixed pipeline latency with a one-cycle `data_valid` strobe per request. Sits between the cache fill logic (instruction and data sides) and the backing storage array, so the whole multi-cycle miss path is modeled in RTL.

## Interface
- `LATENCY`, 4, cycles from read acceptance to `data_valid`; legal range 1..8
- `AW`, 12, word-address width; storage holds 2^AW 16-bit words

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `enable`  in  1  request present this cycle
- `wr`  in  1  1 = write request, 0 = read request (qualified by `enable`)
- `addr`  in  16  byte address; word index = `addr[AW:1]`, bits above AW ignored (aliasing)
- `data_in`  in  16  write data
- `data_out`  out  16  read data, meaningful only when `data_valid`=1, else 16'h0000
- `data_valid`  out  1  one-cycle strobe per completed read
- `err`  out  1  misaligned-read flag, coincident with `data_valid` (see Configuration)

## Operation
- Request sampled at rising edge when `enable`=1.
- Write (`enable`=1, `wr`=1): `mem[addr[AW:1]] <= data_in` at that edge; produces no `data_valid`.
- Read (`enable`=1, `wr`=0): array read at acceptance (snapshot), data pushed into LATENCY-stage shift pipeline of {valid, data, err}.
- Fully pipelined: one read accepted every cycle, no backpressure, no busy output; returns strictly in request order.
- Pipeline stage 0 loaded with valid=0 on idle or write cycles (bubbles preserved).
- Output stage drives `data_out`/`data_valid`/`err`; `data_out` forced 16'h0000 when stage valid=0.
- Storage contents not reset; reads of never-written words return X in simulation.

## Timing
- Read accepted at edge closing cycle n -> `data_valid`=1 during cycle n+LATENCY exactly.
- LATENCY=1: output visible immediately after accepting edge.
- Read-after-write, same address, write in cycle n, read in cycle n+1 or later: returns new data.
- Write to an address with a read to it already in flight: in-flight read returns old (snapshot) data.
- `enable`=1 with `wr`=1: write only, never a read.
- Back-to-back reads of 8 consecutive words: 8 consecutive `data_valid` cycles, no gaps.
- Reset values: `data_out`=16'h0000, `data_valid`=0, `err`=0, all pipeline valids 0.
- Reset asserted mid-operation: in-flight reads discarded immediately (async); no `data_valid` after release until a new read completes; writes during reset ignored.
- `enable` sampled low in same cycle as reset release: no action.

## Configuration
- `MEM_MISALIGN_ERR_EN` defined: read with `addr[0]`=1 still returns `mem[addr[AW:1]]` but sets `err`=1 with its `data_valid`; write with `addr[0]`=1 dropped (array unchanged).
- Not defined: `addr[0]` ignored for reads and writes; `err` tied to 0.

## Test plan
- Reset, write 16'hBEEF to 16'h0010, read 16'h0010 next cycle -> `data_valid`=1 with 16'hBEEF exactly LATENCY cycles after read; `data_out`=0 every other cycle.
- Write 16'h1000+i to addresses 16'h0040+2i (i=0..7), then 8 back-to-back reads -> 8 consecutive valid cycles returning 16'h1000..16'h1007 in order.
- Read 16'h0020 (holds 16'h1111), write 16'h2222 there next cycle -> read returns 16'h1111; subsequent read returns 16'h2222.
- Issue 3 reads, assert `rst_n`=0 one cycle later for 2 cycles -> `data_valid` drops at once, no strobe for any of the 3 after release.
- Alternate read/idle/read -> strobes reproduce the 1-cycle gap; with LATENCY=1 and LATENCY=8 builds latency matches exactly.
- `MEM_MISALIGN_ERR_EN` on: read 16'h0011 -> `err`=1 with data of 16'h0010; write 16'hDEAD to 16'h0011 -> 16'h0010 unchanged. Off: same write updates 16'h0010, `err` stays 0.
